// File: rtl/stack_machine_core.sv
// Multi-cycle stack CPU: fetches one instruction per pc, executes it on an internal
// LIFO of signed words and publishes every pushed value on result.
module stack_machine_core #(
   parameter int DATA_WIDTH  = 8,
   parameter int STACK_DEPTH = 4,
   parameter int INSTR_WIDTH = 12,
   parameter int PC_WIDTH    = 5
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [INSTR_WIDTH-1:0]               instruction,
   output logic [PC_WIDTH-1:0]                  pc,
   output logic signed [DATA_WIDTH-1:0]         result,
   output logic                                 valid_result,
   output logic                                 error,
   output logic                                 halt,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     depth
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int IMM_W   = INSTR_WIDTH - 3;
   localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
   localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

   localparam logic [2:0] OP_PUSH = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_INV  = 3'b101;
   localparam logic [2:0] OP_NOP  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_POP2   = 3'd1;
   localparam logic [2:0] S_POP1   = 3'd2;
   localparam logic [2:0] S_PUSH   = 3'd3;
   localparam logic [2:0] S_HALTED = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;

   // Signed size cast: sign-extends a narrow immediate, truncates a wide one.
   function automatic logic signed [DATA_WIDTH-1:0] imm_ext(input logic signed [IMM_W-1:0] imm);
      return DATA_WIDTH'(imm);
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] alu(
      input logic [2:0]                    op,
      input logic signed [DATA_WIDTH-1:0]  a,
      input logic signed [DATA_WIDTH-1:0]  b,
      input logic signed [DATA_WIDTH-1:0]  imm
   );
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_INV:  return ~a;
         default: return imm;
      endcase
   endfunction

   logic [2:0]                    state_q, state_d;
   logic [PC_WIDTH-1:0]           pc_q, pc_d;
   logic signed [DATA_WIDTH-1:0]  result_q, result_d;
   logic                          valid_q, valid_d;
   logic                          error_q, error_d;
   logic                          halt_q, halt_d;
   logic [DEPTH_W-1:0]            depth_q, depth_d;
   logic [2:0]                    op_q, op_d;
   logic signed [DATA_WIDTH-1:0]  imm_q, imm_d;
   logic signed [DATA_WIDTH-1:0]  opa_q, opa_d;
   logic signed [DATA_WIDTH-1:0]  opb_q, opb_d;
   logic signed [DATA_WIDTH-1:0]  stack_q [STACK_DEPTH];

   logic [2:0]                    opcode;
   logic signed [IMM_W-1:0]       imm_field;
   logic [IDX_W-1:0]              tos_idx;
   logic [IDX_W-1:0]              wr_idx;
   logic signed [DATA_WIDTH-1:0]  tos;
   logic signed [DATA_WIDTH-1:0]  alu_val;

   assign opcode    = instruction[INSTR_WIDTH-1 -: 3];
   assign imm_field = $signed(instruction[IMM_W-1:0]);
   assign tos_idx   = IDX_W'(depth_q - DEPTH_ONE);
   assign wr_idx    = IDX_W'(depth_q);
   assign tos       = stack_q[tos_idx];
   assign alu_val   = alu(op_q, opa_q, opb_q, imm_q);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      result_d = result_q;
      valid_d  = 1'b0;
      error_d  = error_q;
      halt_d   = halt_q;
      depth_d  = depth_q;
      op_d     = op_q;
      imm_d    = imm_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      case (state_q)
         S_FETCH: begin
            op_d  = opcode;
            imm_d = imm_ext(imm_field);
            pc_d  = pc_q + PC_WIDTH'(1);
            // Stack faults are caught here so the faulting instruction never touches the stack.
            case (opcode)
               OP_PUSH: begin
                  if (depth_q == DEPTH_FULL) begin
                     state_d = S_ERROR;
                     error_d = 1'b1;
                  end else begin
                     state_d = S_PUSH;
                  end
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  if (depth_q < DEPTH_TWO) begin
                     state_d = S_ERROR;
                     error_d = 1'b1;
                  end else begin
                     state_d = S_POP2;
                  end
               end
               OP_INV: begin
                  if (depth_q == '0) begin
                     state_d = S_ERROR;
                     error_d = 1'b1;
                  end else begin
                     state_d = S_POP1;
                  end
               end
               OP_HALT: begin
                  state_d = S_HALTED;
                  halt_d  = 1'b1;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_POP2: begin
            opb_d   = tos;
            depth_d = depth_q - DEPTH_ONE;
            state_d = S_POP1;
         end
         S_POP1: begin
            opa_d   = tos;
            depth_d = depth_q - DEPTH_ONE;
            state_d = S_PUSH;
         end
         S_PUSH: begin
            result_d = alu_val;
            valid_d  = 1'b1;
            depth_d  = depth_q + DEPTH_ONE;
            state_d  = S_FETCH;
         end
         S_HALTED, S_ERROR: state_d = state_q;
         default:           state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         halt_q   <= 1'b0;
         depth_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
         halt_q   <= halt_d;
         depth_q  <= depth_d;
      end
   end

   // Operand and stack storage carry no reset; depth alone defines what is live.
   always_ff @(posedge clk) begin
      op_q  <= op_d;
      imm_q <= imm_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      if (state_q == S_PUSH) stack_q[wr_idx] <= alu_val;
   end

   assign pc           = pc_q;
   assign result       = result_q;
   assign valid_result = valid_q;
   assign error        = error_q;
   assign halt         = halt_q;
   assign depth        = depth_q;
endmodule
